// File: rtl/tatsujin_pkg.sv
// Shared lane definitions for the drum-judging pipeline: lane indices, lane FSM
// encoding and a small popcount helper.
package tatsujin_pkg;

  localparam int unsigned NUM_LANES   = 3;
  localparam int unsigned LANE_RED    = 2;
  localparam int unsigned LANE_YELLOW = 1;
  localparam int unsigned LANE_BLUE   = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_HIT       = 2'd2,
    ST_PENALISED = 2'd3
  } lane_state_e;

  function automatic logic [1:0] popcount_lanes(input logic [NUM_LANES-1:0] v);
    logic [1:0] c;
    c = '0;
    for (int i = 0; i < NUM_LANES; i++) c = c + 2'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/key_press_sync.sv
// Raw active-low push button to one-cycle press strobe: 2-FF synchroniser, then
// falling-edge detect, or a low-level debounce when NOTE_JUDGE_DEBOUNCE_EN is defined.
module key_press_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic press_q, press_d;

  assign press = press_q;

  if (DEBOUNCE_CYCLES == 0) begin : g_cfg_check
    $error("key_press_sync: DEBOUNCE_CYCLES must be at least 1");
  end

`ifdef NOTE_JUDGE_DEBOUNCE_EN
  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  // NOTE: every _d gets its default before any branch, so no path can infer a latch.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (sync2_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q != CNT_DONE) begin
      cnt_d = cnt_q + 1'b1;
    end else if (armed_q) begin
      press_d = 1'b1;
      armed_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end
`else
  logic prev_q, prev_d;

  // NOTE: every _d gets its default before any branch, so no path can infer a latch.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press_d = prev_q & ~sync2_q;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end
`endif

endmodule

// File: rtl/note_judge.sv
// Judges drum hits per lane against the note window and keeps combo statistics.
// Optional press debounce is enabled with the NOTE_JUDGE_DEBOUNCE_EN macro.
module note_judge
  import tatsujin_pkg::*;
#(
  parameter int unsigned COMBO_W         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 beat_tick,
  input  logic [NUM_LANES-1:0] lane_head,
  input  logic [NUM_LANES-1:0] key_n,
  output logic [1:0]           hit_cnt,
  output logic [1:0]           miss_cnt,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [NUM_LANES-1:0] lane_flash,
  output logic [COMBO_W-1:0]   combo,
  output logic [COMBO_W-1:0]   max_combo
);

  logic [NUM_LANES-1:0] press;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_key
    key_press_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (clk),
      .reset (reset),
      .key_n (key_n[g]),
      .press (press[g])
    );
  end

  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic [NUM_LANES-1:0] hit_d, miss_d;
  logic [1:0]           hit_cnt_q, hit_cnt_d;
  logic [1:0]           miss_cnt_q, miss_cnt_d;
  logic [COMBO_W-1:0]   combo_q, combo_d;
  logic [COMBO_W-1:0]   max_combo_q, max_combo_d;
  logic [COMBO_W:0]     combo_sum;

  always_comb begin
    hit_d  = '0;
    miss_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      if (press[i]) begin
        case (state_q[i])
          ST_ARMED: begin
            hit_d[i]   = 1'b1;
            state_d[i] = ST_HIT;
          end
          ST_IDLE: begin
            miss_d[i]  = 1'b1;
            state_d[i] = ST_PENALISED;
          end
          default: ;
        endcase
      end
      // A press landing on the tick is judged against the closing window first.
      if (beat_tick) begin
        if (state_q[i] == ST_ARMED && !hit_d[i]) miss_d[i] = 1'b1;
        state_d[i] = lane_head[i] ? ST_ARMED : ST_IDLE;
      end
    end

    hit_cnt_d  = popcount_lanes(hit_d);
    miss_cnt_d = popcount_lanes(miss_d);

    combo_sum = {1'b0, combo_q} + (COMBO_W + 1)'(hit_cnt_d);
    if (miss_cnt_d != 2'd0)  combo_d = '0;
    else if (combo_sum[COMBO_W]) combo_d = '1;
    else                     combo_d = combo_sum[COMBO_W-1:0];
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) state_q[i] <= ST_IDLE;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) state_q[i] <= state_d[i];
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) lane_flash[i] = (state_q[i] == ST_HIT);
  end

  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign hit_pulse  = |hit_cnt_q;
  assign miss_pulse = |miss_cnt_q;
  assign combo      = combo_q;
  assign max_combo  = max_combo_q;

endmodule

// File: tb/tb_note_judge.sv
// Self-checking bench for note_judge: directed scenarios plus random traffic
// compared against a window/judgement reference model.
module tb_note_judge;

`ifdef NOTE_JUDGE_DEBOUNCE_EN
  localparam int unsigned DB = 8;
`else
  localparam int unsigned DB = 250000;
`endif

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       beat_tick = 1'b0;
  logic [2:0] lane_head = 3'b000;
  logic [2:0] key_n     = 3'b111;
  logic [1:0] hit_cnt, miss_cnt;
  logic       hit_pulse, miss_pulse;
  logic [2:0] lane_flash;
  logic [7:0] combo, max_combo;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  note_judge #(.COMBO_W(8), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .beat_tick  (beat_tick),
    .lane_head  (lane_head),
    .key_n      (key_n),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .lane_flash (lane_flash),
    .combo      (combo),
    .max_combo  (max_combo)
  );

  wire [24:0] act = {hit_cnt, miss_cnt, hit_pulse, miss_pulse, lane_flash, combo, max_combo};

  // Reference model: per-lane note presence and "already judged" flag for the window.
  typedef struct { int due; int lane; } press_t;
  logic [2:0] m_note, m_judged, m_flash, last_keys;
  int         m_hit, m_miss, m_combo, m_max;
  int         cyc = 0;
  press_t     pq[$];

  function automatic logic [24:0] expv();
    return {2'(m_hit), 2'(m_miss), m_hit != 0, m_miss != 0, m_flash, 8'(m_combo), 8'(m_max)};
  endfunction

  task automatic model_clear();
    m_note = '0; m_judged = '0; m_flash = '0;
    m_hit = 0; m_miss = 0; m_combo = 0; m_max = 0;
    last_keys = 3'b111;
    pq.delete();
  endtask

  // Apply one cycle of inputs at the falling edge, advance the model at the rising edge.
  task automatic step(input logic b, input logic [2:0] h, input logic [2:0] k);
    logic [2:0] p;
    beat_tick = b; lane_head = h; key_n = k;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++)
      if (k[i] == 1'b0 && last_keys[i] == 1'b1) pq.push_back('{cyc + 3, i});
    last_keys = k;
    p = '0;
    for (int j = pq.size() - 1; j >= 0; j--)
      if (pq[j].due == cyc) begin p[pq[j].lane] = 1'b1; pq.delete(j); end
    m_hit = 0; m_miss = 0;
    for (int i = 0; i < 3; i++) begin
      if (p[i] && !m_judged[i]) begin
        m_judged[i] = 1'b1;
        if (m_note[i]) begin m_hit++; m_flash[i] = 1'b1; end
        else m_miss++;
      end
      if (b) begin
        if (m_note[i] && !m_judged[i]) m_miss++;
        m_note[i] = h[i]; m_judged[i] = 1'b0; m_flash[i] = 1'b0;
      end
    end
    if (m_miss > 0) m_combo = 0;
    else m_combo = (m_combo + m_hit > 255) ? 255 : m_combo + m_hit;
    if (m_combo > m_max) m_max = m_combo;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; beat_tick = 1'b0; lane_head = '0; key_n = 3'b111;
    repeat (2) @(negedge clk);
    model_clear();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (act !== 25'd0) begin bad++; $display("FAIL reset_state got=%h want=0", act); end
    model_clear();
    reset = 1'b0;
    for (int t = 0; t < 100; t++) begin
      step(1'b0, 3'b000, 3'b111);
      total++;
      if (act !== expv()) begin bad++; $display("FAIL idle t=%0d got=%h want=%h", t, act, expv()); end
    end
  endtask

`ifdef NOTE_JUDGE_DEBOUNCE_EN
  task automatic test_debounce();
    int hs, ms;
    do_reset();
    beat_tick = 1'b1; lane_head = 3'b100; @(negedge clk);
    beat_tick = 1'b0; lane_head = 3'b000;
    hs = 0; ms = 0;
    key_n = 3'b011;
    repeat (5) begin @(negedge clk); hs += hit_cnt; ms += miss_cnt; end
    key_n = 3'b111;
    repeat (20) begin @(negedge clk); hs += hit_cnt; ms += miss_cnt; end
    total++;
    if (hs + ms !== 0) begin bad++; $display("FAIL glitch events got=%0d want=0", hs + ms); end
    hs = 0; ms = 0;
    key_n = 3'b011;
    repeat (20) begin @(negedge clk); hs += hit_cnt; ms += miss_cnt; end
    key_n = 3'b111;
    repeat (20) begin @(negedge clk); hs += hit_cnt; ms += miss_cnt; end
    total++;
    if (hs !== 1 || ms !== 0) begin bad++; $display("FAIL hold hits=%0d misses=%0d want 1/0", hs, ms); end
  endtask
`else
  task automatic test_hit_red();
    do_reset();
    for (int t = 0; t <= 17; t++) begin
      step(t == 0 || t == 15, (t == 0) ? 3'b100 : 3'b000, (t == 5 || t == 6) ? 3'b011 : 3'b111);
      total++;
      if (act !== expv()) begin bad++; $display("FAIL hit_red t=%0d got=%h want=%h", t, act, expv()); end
      if (t == 8) begin
        total++;
        if (hit_cnt !== 2'd1) begin bad++; $display("FAIL hit_red_latency got=%0d want=1", hit_cnt); end
      end
      if (t == 9) begin
        total++;
        if ({lane_flash, combo} !== {3'b100, 8'd1}) begin
          bad++; $display("FAIL hit_red_flash got=%b/%0d want=100/1", lane_flash, combo);
        end
      end
      if (t == 15) begin
        total++;
        if (lane_flash !== 3'b000) begin bad++; $display("FAIL flash_clear got=%b want=000", lane_flash); end
      end
    end
  endtask

  task automatic test_miss_combo();
    logic [2:0] h, k;
    do_reset();
    for (int t = 0; t <= 34; t++) begin
      case (t)
        0, 8:    h = 3'b111;
        16:      h = 3'b100;
        24:      h = 3'b101;
        default: h = 3'b000;
      endcase
      k = ((t % 8 == 1 || t % 8 == 2) && t < 24) ? ((t < 16) ? 3'b000 : 3'b011) : 3'b111;
      step((t % 8 == 0) && t <= 32, h, k);
      total++;
      if (act !== expv()) begin bad++; $display("FAIL miss_combo t=%0d got=%h want=%h", t, act, expv()); end
      if (t == 32) begin
        total++;
        if ({miss_cnt, combo, max_combo} !== {2'd2, 8'd0, 8'd7}) begin
          bad++; $display("FAIL miss2 got=%0d/%0d/%0d want=2/0/7", miss_cnt, combo, max_combo);
        end
      end
      if (t == 33) begin
        total++;
        if (miss_cnt !== 2'd0) begin bad++; $display("FAIL miss_one_cycle got=%0d want=0", miss_cnt); end
      end
    end
  endtask

  task automatic test_double_press();
    int msum;
    msum = 0;
    do_reset();
    for (int t = 0; t <= 12; t++) begin
      step(t == 0, 3'b000, (t == 2 || t == 3 || t == 6 || t == 7) ? 3'b110 : 3'b111);
      msum += miss_cnt;
      total++;
      if (act !== expv()) begin bad++; $display("FAIL double_press t=%0d got=%h want=%h", t, act, expv()); end
    end
    total++;
    if (msum !== 1) begin bad++; $display("FAIL double_press_total got=%0d want=1", msum); end
  endtask

  task automatic test_same_cycle();
    logic [2:0] h;
    do_reset();
    for (int t = 0; t <= 16; t++) begin
      h = (t == 0) ? 3'b100 : (t == 10) ? 3'b011 : 3'b000;
      step(t == 0 || t == 10 || t == 14, h, (t == 7 || t == 8) ? 3'b011 : 3'b111);
      total++;
      if (act !== expv()) begin bad++; $display("FAIL same_cycle t=%0d got=%h want=%h", t, act, expv()); end
      if (t == 10) begin
        total++;
        if ({hit_cnt, miss_cnt} !== {2'd1, 2'd0}) begin
          bad++; $display("FAIL same_cycle_judge got=%0d/%0d want=1/0", hit_cnt, miss_cnt);
        end
      end
      if (t == 14) begin
        total++;
        if (miss_cnt !== 2'd2) begin bad++; $display("FAIL new_window_load got=%0d want=2", miss_cnt); end
      end
    end
  endtask

  task automatic test_saturation();
    int w, ph;
    do_reset();
    for (int t = 0; t <= 519; t++) begin
      w = t / 6; ph = t % 6;
      step(ph == 0, (w == 84) ? 3'b110 : 3'b111,
           (ph == 1 || ph == 2) ? ((w == 84) ? 3'b001 : 3'b000) : 3'b111);
      total++;
      if (act !== expv()) begin bad++; $display("FAIL saturation t=%0d got=%h want=%h", t, act, expv()); end
      if (t == 508) begin
        total++;
        if (combo !== 8'd254) begin bad++; $display("FAIL combo_254 got=%0d want=254", combo); end
      end
      if (t == 514) begin
        total++;
        if ({combo, max_combo} !== {8'd255, 8'd255}) begin
          bad++; $display("FAIL combo_sat got=%0d/%0d want=255/255", combo, max_combo);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int t = 0; t <= 5; t++) step(t == 0, (t == 0) ? 3'b111 : 3'b000, (t == 1 || t == 2) ? 3'b011 : 3'b111);
    reset = 1'b1;
    #2;
    total++;
    if (act !== 25'd0) begin bad++; $display("FAIL async_reset got=%h want=0", act); end
    @(negedge clk);
    model_clear();
    reset = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      step(t == 0, 3'b000, 3'b111);
      total++;
      if (act !== expv()) begin bad++; $display("FAIL mid_reset t=%0d got=%h want=%h", t, act, expv()); end
    end
  endtask

  task automatic test_random();
    logic [2:0] k;
    k = 3'b111;
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 3) == 0) k[i] = ~k[i];
      step($urandom_range(0, 9) == 0, 3'($urandom), k);
      total++;
      if (act !== expv()) begin bad++; $display("FAIL random t=%0d got=%h want=%h", t, act, expv()); end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
`ifdef NOTE_JUDGE_DEBOUNCE_EN
    test_debounce();
`else
    test_hit_red();
    test_miss_combo();
    test_double_press();
    test_same_cycle();
    test_saturation();
    do_reset();
    test_mid_reset();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
